// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle sequencer for R/I-format ALU instructions: FETCH, DECODE, EXEC, [WAIT], LATCH, WRITE.
// Optional macro SEQ_R0_GUARD_EN suppresses register-file writes to R0.
module rtype_seq_ctrl #(
  parameter int ADDR_W        = 4,
  parameter int CTRL_W        = 4,
  parameter int IMM_W         = 19,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iStart,
  input  logic [31:0]       iMemData,
  output logic              oPC_en,
  output logic              oPC_jmp,
  output logic              oMUX_MAP,
  output logic [ADDR_W-1:0] oRF_AddrA,
  output logic [ADDR_W-1:0] oRF_AddrB,
  output logic [ADDR_W-1:0] oRF_AddrC,
  output logic              oRA_en,
  output logic              oRB_en,
  output logic              oRZH_en,
  output logic              oRZL_en,
  output logic              oRWB_en,
  output logic              oRF_Write,
  output logic [CTRL_W-1:0] oALU_Ctrl,
  output logic              oMUX_BIS,
  output logic              oMUX_RZHS,
  output logic [31:0]       oImm32,
  output logic              oBusy,
  output logic              oDone,
  output logic              oIllegal
);

  // ISA opcodes
  localparam logic [4:0] ISA_ADD  = 5'd0,  ISA_SUB  = 5'd1,  ISA_AND  = 5'd2,  ISA_OR   = 5'd3;
  localparam logic [4:0] ISA_SHR  = 5'd4,  ISA_SHRA = 5'd5,  ISA_SHL  = 5'd6,  ISA_ROR  = 5'd7;
  localparam logic [4:0] ISA_ROL  = 5'd8,  ISA_ADDI = 5'd9,  ISA_ANDI = 5'd10, ISA_ORI  = 5'd11;
  localparam logic [4:0] ISA_MUL  = 5'd12, ISA_DIV  = 5'd13, ISA_NEG  = 5'd14, ISA_NOT  = 5'd15;

  // ALU operation codes
  localparam logic [3:0] CTRL_ALU_ADD  = 4'd0,  CTRL_ALU_SUB = 4'd1, CTRL_ALU_AND = 4'd2;
  localparam logic [3:0] CTRL_ALU_OR   = 4'd3,  CTRL_ALU_SHR = 4'd4, CTRL_ALU_SHRA = 4'd5;
  localparam logic [3:0] CTRL_ALU_SHL  = 4'd6,  CTRL_ALU_ROR = 4'd7, CTRL_ALU_ROL = 4'd8;
  localparam logic [3:0] CTRL_ALU_MUL  = 4'd9,  CTRL_ALU_DIV = 4'd10, CTRL_ALU_NEG = 4'd11;
  localparam logic [3:0] CTRL_ALU_NOT  = 4'd12;

  localparam int CNT_W = $clog2(MULDIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MULDIV_CYCLES > 1 ? MULDIV_CYCLES - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_LATCH, S_WRITE
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       ir_reg;

  logic              pc_reg, ra_en_reg, rb_en_reg, rz_en_reg, rwb_reg;
  logic              rf_write_reg, done_reg, illegal_reg, busy_reg, bis_reg;
  logic [ADDR_W-1:0] addr_a_reg, addr_b_reg, addr_c_reg;
  logic [CTRL_W-1:0] alu_reg;
  logic [31:0]       imm_reg;

  // Outputs are registered from the next state, so the word being decoded
  // during FETCH is the one on the memory bus, not the IR.
  logic [31:0] word;
  logic [4:0]  opcode;
  logic [3:0]  rdest, rsrc_a, rsrc_b;
  logic [31:0] imm32;
  logic        legal, is_imm, is_muldiv, write_allowed;
  logic [3:0]  ctrl;

  assign word   = (state_reg == S_FETCH) ? iMemData : ir_reg;
  assign opcode = word[31:27];
  assign rdest  = word[26:23];
  assign rsrc_a = word[22:19];
  assign rsrc_b = word[18:15];
  assign imm32  = {{(32-IMM_W){word[IMM_W-1]}}, word[IMM_W-1:0]};

`ifdef SEQ_R0_GUARD_EN
  assign write_allowed = (rdest != 4'd0);
`else
  assign write_allowed = 1'b1;
`endif

  always_comb begin
    legal     = 1'b1;
    is_imm    = 1'b0;
    is_muldiv = 1'b0;
    ctrl      = CTRL_ALU_ADD;
    case (opcode)
      ISA_ADD:  ctrl = CTRL_ALU_ADD;
      ISA_SUB:  ctrl = CTRL_ALU_SUB;
      ISA_AND:  ctrl = CTRL_ALU_AND;
      ISA_OR:   ctrl = CTRL_ALU_OR;
      ISA_SHR:  ctrl = CTRL_ALU_SHR;
      ISA_SHRA: ctrl = CTRL_ALU_SHRA;
      ISA_SHL:  ctrl = CTRL_ALU_SHL;
      ISA_ROR:  ctrl = CTRL_ALU_ROR;
      ISA_ROL:  ctrl = CTRL_ALU_ROL;
      ISA_ADDI: begin ctrl = CTRL_ALU_ADD; is_imm = 1'b1; end
      ISA_ANDI: begin ctrl = CTRL_ALU_AND; is_imm = 1'b1; end
      ISA_ORI:  begin ctrl = CTRL_ALU_OR;  is_imm = 1'b1; end
      ISA_MUL:  begin ctrl = CTRL_ALU_MUL; is_muldiv = 1'b1; end
      ISA_DIV:  begin ctrl = CTRL_ALU_DIV; is_muldiv = 1'b1; end
      ISA_NEG:  ctrl = CTRL_ALU_NEG;
      ISA_NOT:  ctrl = CTRL_ALU_NOT;
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE:   if (iStart) state_next = S_FETCH;
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_IDLE;
      S_EXEC: begin
        if (is_muldiv && MULDIV_CYCLES > 1) begin
          state_next = S_WAIT;
          cnt_next   = WAIT_LOAD;
        end else begin
          state_next = S_LATCH;
        end
      end
      S_WAIT: begin
        if (cnt_reg == '0) state_next = S_LATCH;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      S_LATCH:  state_next = S_WRITE;
      S_WRITE:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      ir_reg       <= '0;
      pc_reg       <= 1'b0;
      ra_en_reg    <= 1'b0;
      rb_en_reg    <= 1'b0;
      rz_en_reg    <= 1'b0;
      rwb_reg      <= 1'b0;
      rf_write_reg <= 1'b0;
      done_reg     <= 1'b0;
      illegal_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      bis_reg      <= 1'b0;
      addr_a_reg   <= '0;
      addr_b_reg   <= '0;
      addr_c_reg   <= '0;
      alu_reg      <= '0;
      imm_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      if (state_reg == S_FETCH) ir_reg <= iMemData;
      pc_reg       <= (state_next == S_FETCH);
      ra_en_reg    <= (state_next == S_DECODE) && legal;
      rb_en_reg    <= (state_next == S_DECODE) && legal && !is_imm;
      illegal_reg  <= (state_next == S_DECODE) && !legal;
      rz_en_reg    <= (state_next == S_EXEC) || ((state_next == S_WAIT) && (cnt_next == '0));
      rwb_reg      <= (state_next == S_LATCH);
      rf_write_reg <= (state_next == S_WRITE) && write_allowed;
      done_reg     <= (state_next == S_WRITE);
      busy_reg     <= (state_next != S_IDLE);
      // Decoded fields are captured on entry to DECODE and held until IDLE.
      if (state_next == S_IDLE) begin
        bis_reg    <= 1'b0;
        addr_a_reg <= '0;
        addr_b_reg <= '0;
        addr_c_reg <= '0;
        alu_reg    <= '0;
        imm_reg    <= '0;
      end else if (state_reg == S_FETCH) begin
        bis_reg    <= legal && is_imm;
        addr_a_reg <= ADDR_W'(rsrc_a);
        addr_b_reg <= ADDR_W'(rsrc_b);
        addr_c_reg <= ADDR_W'(rdest);
        alu_reg    <= legal ? CTRL_W'(ctrl) : '0;
        imm_reg    <= imm32;
      end
    end
  end

  assign oPC_en    = pc_reg;
  assign oPC_jmp   = pc_reg;
  assign oMUX_MAP  = pc_reg;
  assign oRF_AddrA = addr_a_reg;
  assign oRF_AddrB = addr_b_reg;
  assign oRF_AddrC = addr_c_reg;
  assign oRA_en    = ra_en_reg;
  assign oRB_en    = rb_en_reg;
  assign oRZH_en   = rz_en_reg;
  assign oRZL_en   = rz_en_reg;
  assign oRWB_en   = rwb_reg;
  assign oRF_Write = rf_write_reg;
  assign oALU_Ctrl = alu_reg;
  assign oMUX_BIS  = bis_reg;
  // Every supported operation writes back from the low half of Z.
  assign oMUX_RZHS = 1'b0;
  assign oImm32    = imm_reg;
  assign oBusy     = busy_reg;
  assign oDone     = done_reg;
  assign oIllegal  = illegal_reg;

endmodule
